// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the execute-stage arithmetic blocks.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_N_DEFAULT = 32;

    // Width of an iteration counter that must hold the value n itself.
    function automatic int div_cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_N_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep or restore depending on the borrow.
module div_step #(
    parameter int n = 32
) (
    input  logic [n:0]   rem_i,
    input  logic         bit_i,
    input  logic [n-1:0] dvs_i,
    output logic [n:0]   rem_o,
    output logic         q_o
);

    logic [n:0] shifted;
    logic [n:0] diff;
    logic       borrow_raw;
    logic       borrow;

    assign shifted = {rem_i[n-1:0], bit_i};
    assign {borrow_raw, diff} = {1'b0, shifted} - {2'b00, dvs_i};

    // A set top bit means the shifted value already exceeds any n-bit divisor.
    assign borrow = borrow_raw & ~rem_i[n];

    assign q_o   = ~borrow;
    assign rem_o = borrow ? shifted : diff;

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake for pipeline stalling.
module seq_divider
    import alu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = div_cnt_width(n);

    div_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n:0]   rem_q, rem_d;
    logic [n-1:0] dvd_q, dvd_d;
    logic [n-1:0] dvs_q, dvs_d;
    logic         neg_quo_q, neg_quo_d;
    logic         neg_rem_q, neg_rem_d;
    logic [n-1:0] quo_q, quo_d;
    logic [n-1:0] rmd_q, rmd_d;
    logic         dbz_q, dbz_d;

    logic [n-1:0] a_mag, b_mag;
    logic [n:0]   step_rem;
    logic         step_q;

    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign a_mag = (signed_op && a[n-1]) ? -a : a;
    assign b_mag = (signed_op && b[n-1]) ? -b : b;

    div_step #(.n(n)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[n-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = a;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d   = RUN;
                        cnt_d     = CW'(n);
                        rem_d     = '0;
                        dvd_d     = a_mag;
                        dvs_d     = b_mag;
                        neg_quo_d = signed_op & (a[n-1] ^ b[n-1]);
                        neg_rem_d = signed_op & a[n-1];
                        dbz_d     = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[n-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = neg_quo_q ? -dvd_q : dvd_q;
                rmd_d   = neg_rem_q ? -rem_q[n-1:0] : rem_q[n-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider: expected results are queued at start
// and compared when the done pulse appears.
module tb_seq_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.n(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [N-1:0] q, input logic [N-1:0] r, input logic dbz);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Drive a request so it is sampled at the next rising edge (E0).
    task automatic issue(input logic so, input logic [N-1:0] av, input logic [N-1:0] bv, input exp_t e);
        @(negedge clk);
        start     = 1'b1;
        signed_op = so;
        a         = av;
        b         = bv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Latency is counted in edges after E0 at which done is first captured high.
    // inj_at >= 0 drives an extra 9/9 request while the divider is busy.
    task automatic wait_done(input string tag, input int exp_lat, input int inj_at);
        int   j = 0;
        bit   seen = 1'b0;
        int   busy_bad = 0;
        logic busy_at_done = 1'b1;
        exp_t e;
        while (j < 80 && !seen) begin
            @(negedge clk);
            if (inj_at >= 0 && j == inj_at) begin
                start     = 1'b1;
                signed_op = 1'b0;
                a         = 9;
                b         = 9;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                seen         = 1'b1;
                busy_at_done = busy;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
            j++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, N'(seen), N'(1));
        chk({tag, " latency"}, N'(j), N'(exp_lat));
        chk({tag, " busy_while_running"}, N'(busy_bad), N'(0));
        chk({tag, " busy_at_done"}, N'(busy_at_done), N'(0));
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " quotient"}, quotient, e.q);
            chk({tag, " remainder"}, remainder, e.r);
            chk({tag, " div_by_zero"}, N'(div_by_zero), N'(e.dbz));
            @(negedge clk);
            chk({tag, " done_single_pulse"}, N'(done), N'(0));
            chk({tag, " quotient_held"}, quotient, e.q);
        end
        $display("op %s: latency=%0d q=0x%08h r=0x%08h dbz=%0b", tag, j, quotient, remainder, div_by_zero);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra_done;

        #1 reset = 1'b1;
        #2;
        chk("reset busy", N'(busy), N'(0));
        chk("reset done", N'(done), N'(0));
        chk("reset quotient", quotient, '0);
        chk("reset remainder", remainder, '0);
        chk("reset dbz", N'(div_by_zero), N'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
        wait_done("u100/7", N + 2, -1);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
        wait_done("s-7/2", N + 2, -1);

        issue(1'b0, 32'hFFFF_FFF9, 32'd2, mk(32'h7FFF_FFFC, 32'd1, 1'b0));
        wait_done("uFFFFFFF9/2", N + 2, -1);

        issue(1'b1, 32'd7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0));
        wait_done("s7/-2", N + 2, -1);

        issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, mk(32'd3, 32'hFFFF_FFFF, 1'b0));
        wait_done("s-7/-2", N + 2, -1);

        issue(1'b0, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1));
        wait_done("u5/0", 1, -1);

        issue(1'b1, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1));
        wait_done("s5/0", 1, -1);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0));
        wait_done("s_overflow", N + 2, -1);

        issue(1'b1, 32'h8000_0000, 32'd1, mk(32'h8000_0000, 32'd0, 1'b0));
        wait_done("s_min/1", N + 2, -1);

        issue(1'b0, 32'd20, 32'd3, mk(32'd6, 32'd2, 1'b0));
        wait_done("u20/3_ignore_start", N + 2, 4);
        extra_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        chk("u20/3 extra_done_pulses", N'(extra_done), N'(0));

        issue(1'b0, 32'd1000, 32'd10, mk(32'd100, 32'd0, 1'b0));
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midop_reset busy", N'(busy), N'(0));
        chk("midop_reset done", N'(done), N'(0));
        chk("midop_reset quotient", quotient, '0);
        chk("midop_reset remainder", remainder, '0);
        chk("midop_reset dbz", N'(div_by_zero), N'(0));
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        chk("midop_reset no_done", N'(extra_done), N'(0));
        $display("op u1000/10: abandoned by reset, done pulses afterwards=%0d", extra_done);

        issue(1'b0, 32'd9, 32'd4, mk(32'd2, 32'd1, 1'b0));
        wait_done("u9/4_after_reset", N + 2, -1);

        chk("scoreboard empty", N'(sb.size()), N'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
